// File: rtl/rat_io_pkg.sv
// Shared definitions for the RAT MCU I/O hub: the byte type, default port IDs and a window-overlap helper.
package rat_io_pkg;

  typedef logic [7:0] io_byte_t;

  localparam io_byte_t SWITCHES_ID = 8'h20;
  localparam io_byte_t LEDS_ID     = 8'h40;
  localparam io_byte_t SSEG_ID     = 8'h41;
  localparam io_byte_t IRQ_PEND_ID = 8'hF0;
  localparam io_byte_t IRQ_MASK_ID = 8'hF1;

  // True when the half-open windows [a, a+na) and [b, b+nb) share any address.
  function automatic logic windows_overlap(input int a, input int na, input int b, input int nb);
    return (a < b + nb) && (b < a + na);
  endfunction

endpackage

// File: rtl/io_sync.sv
// Plain multi-flop synchroniser chain for asynchronous inputs; every stage clears on reset.
module io_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < STAGES; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_async;
      for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_sync = r_stage[STAGES-1];

endmodule

// File: rtl/rat_io_hub.sv
// RAT MCU port-bus I/O hub: synchronised input ports, port-mapped output registers and a
// maskable edge-triggered interrupt controller with pending (W1C) and mask registers.
module rat_io_hub
  import rat_io_pkg::*;
#(
  parameter int       NUM_IN      = 4,
  parameter int       NUM_OUT     = 4,
  parameter int       NUM_IRQ     = 4,
  parameter io_byte_t IN_BASE     = SWITCHES_ID,
  parameter io_byte_t OUT_BASE    = LEDS_ID,
  parameter io_byte_t IRQ_BASE    = IRQ_PEND_ID,
  parameter int       SYNC_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [7:0]           PORT_ID,
  input  logic [7:0]           OUT_PORT,
  input  logic                 IO_STRB,
  output logic [7:0]           IN_PORT,
  input  logic [NUM_IN*8-1:0]  IN_DATA,
  output logic [NUM_OUT*8-1:0] OUT_DATA,
  input  logic [NUM_IRQ-1:0]   IRQ_SRC,
  output logic                 INTERRUPT
);

  localparam int       IN_LO         = int'(IN_BASE);
  localparam int       OUT_LO        = int'(OUT_BASE);
  localparam int       IRQ_LO        = int'(IRQ_BASE);
  localparam io_byte_t IRQ_MASK_ADDR = 8'(IRQ_LO + 1);

  if (NUM_IN < 1 || NUM_IN > 16 || NUM_OUT < 1 || NUM_OUT > 16 ||
      NUM_IRQ < 1 || NUM_IRQ > 8 || SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_param
    $fatal(1, "rat_io_hub: parameter out of legal range");
  end
  if (IN_LO + NUM_IN > 256 || OUT_LO + NUM_OUT > 256 || IRQ_LO + 2 > 256) begin : g_bad_fit
    $fatal(1, "rat_io_hub: address window exceeds 8'hFF");
  end
  if (windows_overlap(IN_LO, NUM_IN, OUT_LO, NUM_OUT) ||
      windows_overlap(IN_LO, NUM_IN, IRQ_LO, 2) ||
      windows_overlap(OUT_LO, NUM_OUT, IRQ_LO, 2)) begin : g_bad_overlap
    $fatal(1, "rat_io_hub: address windows overlap");
  end

  logic [NUM_IN*8-1:0] w_in_sync;
  logic [NUM_IRQ-1:0]  w_irq_sync;
  logic [NUM_IRQ-1:0]  w_rise;
  logic [NUM_IRQ-1:0]  w_w1c;
  logic                w_pend_wr;
  logic                w_mask_wr;
  io_byte_t            w_rd_data;

  logic [NUM_IRQ-1:0]  r_irq_hist;
  logic [NUM_IRQ-1:0]  r_pending;
  logic [NUM_IRQ-1:0]  r_mask;
  logic                r_interrupt;

  io_sync #(.WIDTH(NUM_IN*8), .STAGES(SYNC_STAGES)) u_in_sync (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_async (IN_DATA),
    .o_sync  (w_in_sync)
  );

  io_sync #(.WIDTH(NUM_IRQ), .STAGES(SYNC_STAGES)) u_irq_sync (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_async (IRQ_SRC),
    .o_sync  (w_irq_sync)
  );

  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_out
    localparam io_byte_t ADDR = 8'(OUT_LO + gi);
    io_byte_t r_out;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)                         r_out <= '0;
      else if (IO_STRB && PORT_ID == ADDR) r_out <= OUT_PORT;
    end

    assign OUT_DATA[gi*8 +: 8] = r_out;
  end

  // History clears on reset, so a source already high at release yields one rising edge.
  assign w_rise    = w_irq_sync & ~r_irq_hist;
  assign w_pend_wr = IO_STRB && (PORT_ID == IRQ_BASE);
  assign w_mask_wr = IO_STRB && (PORT_ID == IRQ_MASK_ADDR);
  assign w_w1c     = {NUM_IRQ{w_pend_wr}} & OUT_PORT[NUM_IRQ-1:0];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_irq_hist  <= '0;
      r_pending   <= '0;
      r_mask      <= '0;
      r_interrupt <= 1'b0;
    end else begin
      r_irq_hist  <= w_irq_sync;
      r_pending   <= w_rise | (r_pending & ~w_w1c);
      if (w_mask_wr) r_mask <= OUT_PORT[NUM_IRQ-1:0];
      r_interrupt <= |(r_pending & r_mask);
    end
  end

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (PORT_ID == 8'(IN_LO + i)) w_rd_data = w_in_sync[i*8 +: 8];
    end
    if (PORT_ID == IRQ_BASE)      w_rd_data[NUM_IRQ-1:0] = r_pending;
    if (PORT_ID == IRQ_MASK_ADDR) w_rd_data[NUM_IRQ-1:0] = r_mask;
  end

  assign IN_PORT   = w_rd_data;
  assign INTERRUPT = r_interrupt;

endmodule

// File: tb/tb_rat_io_hub.sv
// Self-checking bench for rat_io_hub: expected values go into a scoreboard queue as stimulus is applied.
module tb_rat_io_hub;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [7:0]  PORT_ID;
  logic [7:0]  OUT_PORT;
  logic        IO_STRB;
  logic [7:0]  IN_PORT;
  logic [31:0] IN_DATA;
  logic [31:0] OUT_DATA;
  logic [3:0]  IRQ_SRC;
  logic        INTERRUPT;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  logic [31:0] out_model;
  logic [7:0]  rd;

  always #5 CLK = ~CLK;

  rat_io_hub dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .PORT_ID   (PORT_ID),
    .OUT_PORT  (OUT_PORT),
    .IO_STRB   (IO_STRB),
    .IN_PORT   (IN_PORT),
    .IN_DATA   (IN_DATA),
    .OUT_DATA  (OUT_DATA),
    .IRQ_SRC   (IRQ_SRC),
    .INTERRUPT (INTERRUPT)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic io_write(input logic [7:0] id, input logic [7:0] d);
    PORT_ID  = id;
    OUT_PORT = d;
    IO_STRB  = 1'b1;
    tick();
    IO_STRB  = 1'b0;
    PORT_ID  = 8'h00;
    OUT_PORT = 8'h00;
    $display("write id=%h data=%h", id, d);
  endtask

  task automatic io_read(input logic [7:0] id, output logic [7:0] d);
    PORT_ID = id;
    #1;
    d = IN_PORT;
    $display("read  id=%h data=%h", id, d);
  endtask

  task automatic test_reset();
    io_write(8'h40, 8'hA5);
    IRQ_SRC = 4'b0011;
    repeat (4) tick();
    exp_q.push_back(32'h03);
    io_read(8'hF0, rd);
    exp_v = exp_q.pop_front();
    n_checks++;
    if ({24'h0, rd} !== exp_v) begin n_fail++; $display("FAIL pre_reset_pending: got %h want %h", rd, exp_v); end
    #2 RST_N = 1'b0;
    #1;
    exp_q.push_back(32'h0);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (OUT_DATA !== exp_v) begin n_fail++; $display("FAIL reset_out_data: got %h want %h", OUT_DATA, exp_v); end
    n_checks++;
    if (INTERRUPT !== 1'b0) begin n_fail++; $display("FAIL reset_interrupt: got %b want 0", INTERRUPT); end
    IRQ_SRC = 4'b0000;
    repeat (2) tick();
    RST_N = 1'b1;
    tick();
    out_model = 32'h0;
    exp_q.push_back(32'h00);
    io_read(8'hF0, rd);
    exp_v = exp_q.pop_front();
    n_checks++;
    if ({24'h0, rd} !== exp_v) begin n_fail++; $display("FAIL reset_pending_read: got %h want %h", rd, exp_v); end
    io_read(8'hF1, rd);
    n_checks++;
    if (rd !== 8'h00) begin n_fail++; $display("FAIL reset_mask_read: got %h want 00", rd); end
  endtask

  task automatic test_output_write();
    out_model[23:16] = 8'h5C;
    exp_q.push_back(out_model);
    io_write(8'h42, 8'h5C);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (OUT_DATA !== exp_v) begin n_fail++; $display("FAIL out_write_42: got %h want %h", OUT_DATA, exp_v); end
    exp_q.push_back(out_model);
    io_write(8'h50, 8'hFF);
    tick();
    exp_v = exp_q.pop_front();
    n_checks++;
    if (OUT_DATA !== exp_v) begin n_fail++; $display("FAIL out_unmapped_50: got %h want %h", OUT_DATA, exp_v); end
    io_read(8'hF1, rd);
    n_checks++;
    if (rd !== 8'h00) begin n_fail++; $display("FAIL unmapped_mask: got %h want 00", rd); end
  endtask

  task automatic test_back_to_back();
    IO_STRB = 1'b1;
    for (int i = 0; i < 4; i++) begin
      PORT_ID  = 8'h40 + 8'(i);
      OUT_PORT = 8'h11 * 8'(i + 1);
      out_model[i*8 +: 8] = OUT_PORT;
      exp_q.push_back(out_model);
      tick();
      exp_v = exp_q.pop_front();
      $display("write id=%h data=%h", PORT_ID, OUT_PORT);
      n_checks++;
      if (OUT_DATA !== exp_v) begin n_fail++; $display("FAIL b2b_write_%0d: got %h want %h", i, OUT_DATA, exp_v); end
    end
    IO_STRB = 1'b0;
    PORT_ID = 8'h00;
  endtask

  task automatic test_input_sync();
    PORT_ID = 8'h21;
    IN_DATA[15:8] = 8'h7E;
    exp_q.push_back(32'h00);
    exp_q.push_back(32'h7E);
    tick();
    exp_v = exp_q.pop_front();
    n_checks++;
    if ({24'h0, IN_PORT} !== exp_v) begin n_fail++; $display("FAIL in_sync_cycle1: got %h want %h", IN_PORT, exp_v); end
    tick();
    exp_v = exp_q.pop_front();
    n_checks++;
    if ({24'h0, IN_PORT} !== exp_v) begin n_fail++; $display("FAIL in_sync_cycle2: got %h want %h", IN_PORT, exp_v); end
    IN_DATA[31:24] = 8'hC3;
    repeat (2) tick();
    io_read(8'h23, rd);
    n_checks++;
    if (rd !== 8'hC3) begin n_fail++; $display("FAIL in_port3: got %h want c3", rd); end
    io_read(8'h30, rd);
    n_checks++;
    if (rd !== 8'h00) begin n_fail++; $display("FAIL in_unmapped_30: got %h want 00", rd); end
  endtask

  task automatic test_irq_latency();
    io_write(8'hF1, 8'h01);
    IRQ_SRC[0] = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (INTERRUPT !== 1'b0) begin n_fail++; $display("FAIL irq_early: got %b want 0", INTERRUPT); end
    tick();
    n_checks++;
    if (INTERRUPT !== 1'b1) begin n_fail++; $display("FAIL irq_edge4: got %b want 1", INTERRUPT); end
    io_read(8'hF0, rd);
    n_checks++;
    if (rd !== 8'h01) begin n_fail++; $display("FAIL irq_pending: got %h want 01", rd); end
    io_write(8'hF0, 8'h01);
    tick();
    n_checks++;
    if (INTERRUPT !== 1'b0) begin n_fail++; $display("FAIL irq_w1c_low: got %b want 0", INTERRUPT); end
    repeat (5) tick();
    io_read(8'hF0, rd);
    n_checks++;
    if (rd !== 8'h00 || INTERRUPT !== 1'b0) begin
      n_fail++; $display("FAIL irq_no_retrigger: pending %h int %b want 00/0", rd, INTERRUPT);
    end
    IRQ_SRC[0] = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_masking();
    io_write(8'hF1, 8'h00);
    IRQ_SRC[2] = 1'b1;
    repeat (4) tick();
    io_read(8'hF0, rd);
    n_checks++;
    if (rd !== 8'h04) begin n_fail++; $display("FAIL mask_pending: got %h want 04", rd); end
    n_checks++;
    if (INTERRUPT !== 1'b0) begin n_fail++; $display("FAIL mask_blocks: got %b want 0", INTERRUPT); end
    io_write(8'hF1, 8'h04);
    tick();
    n_checks++;
    if (INTERRUPT !== 1'b1) begin n_fail++; $display("FAIL unmask_raise: got %b want 1", INTERRUPT); end
    io_write(8'hF0, 8'h04);
    n_checks++;
    if (INTERRUPT !== 1'b1) begin n_fail++; $display("FAIL w1c_hold1: got %b want 1", INTERRUPT); end
    tick();
    n_checks++;
    if (INTERRUPT !== 1'b0) begin n_fail++; $display("FAIL w1c_low2: got %b want 0", INTERRUPT); end
    IRQ_SRC[2] = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_simultaneous();
    io_write(8'hF1, 8'h02);
    IRQ_SRC[1] = 1'b1;
    repeat (4) tick();
    n_checks++;
    if (INTERRUPT !== 1'b1) begin n_fail++; $display("FAIL simul_setup: got %b want 1", INTERRUPT); end
    IRQ_SRC[1] = 1'b0;
    repeat (4) tick();
    IRQ_SRC[1] = 1'b1;
    repeat (2) tick();
    io_write(8'hF0, 8'h02);
    io_read(8'hF0, rd);
    n_checks++;
    if (rd !== 8'h02) begin n_fail++; $display("FAIL simul_pending: got %h want 02", rd); end
    tick();
    n_checks++;
    if (INTERRUPT !== 1'b1) begin n_fail++; $display("FAIL simul_interrupt: got %b want 1", INTERRUPT); end
    tick();
    n_checks++;
    if (INTERRUPT !== 1'b1) begin n_fail++; $display("FAIL simul_interrupt2: got %b want 1", INTERRUPT); end
  endtask

  initial begin
    RST_N    = 1'b0;
    PORT_ID  = 8'h00;
    OUT_PORT = 8'h00;
    IO_STRB  = 1'b0;
    IN_DATA  = 32'h0;
    IRQ_SRC  = 4'h0;
    out_model = 32'h0;
    repeat (3) tick();
    RST_N = 1'b1;
    tick();
    test_reset();
    test_output_write();
    test_back_to_back();
    test_input_sync();
    test_irq_latency();
    test_masking();
    test_simultaneous();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
